// File: rtl/flash_pkg.sv
// Shared types and widths for the flash read arbiter and its round-robin grant logic.
package flash_pkg;

    localparam int FL_ADDR_W = 23;
    localparam int FL_DATA_W = 16;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        DELIVER
    } arb_state_t;

    // Pointer width stays at least one bit so a single-requester build still elaborates.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import flash_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any_req,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [PTR_W-1:0] gnt_idx,
    output logic [PTR_W-1:0] next_ptr
);

    logic found;
    int   idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = PTR_W'(idx);
            end
        end
    end

    assign any_req  = |req;
    assign next_ptr = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one dual-SPI flash word reader between NREQ requesters, one read at a time,
// round-robin, with a boot delay, start strobe, busy handshake and busy-rise timeout/retry.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int BOOT_CYC = 32,
    parameter int CS_HOLD  = 2,
    parameter int BUSY_TO  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*FL_ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]           req_ack,
    output logic [FL_DATA_W-1:0]      rd_data,
    output logic [NREQ-1:0]           rd_valid,
    output logic [FL_ADDR_W-1:0]      fl_a,
    output logic                      fl_cs,
    input  logic [FL_DATA_W-1:0]      fl_o,
    input  logic                      fl_busy,
    output logic                      timeout,
    output arb_state_t                dbg_state
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = 16;

    // Handshake: a requester raises req with a stable address and holds it until the
    // one-cycle req_ack; the result returns later as a one-cycle rd_valid to that requester.

    arb_state_t           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic [NREQ-1:0]      owner, owner_n;
    logic [NREQ-1:0]      req_ack_n, rd_valid_n;
    logic [FL_DATA_W-1:0] rd_data_n;
    logic [FL_ADDR_W-1:0] fl_a_n, gnt_addr;
    logic                 fl_cs_n, timeout_n;

    logic                 any_req;
    logic [NREQ-1:0]      gnt_oh;
    logic [PTR_W-1:0]     gnt_idx, next_ptr;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req      (req),
        .ptr      (ptr),
        .any_req  (any_req),
        .gnt_oh   (gnt_oh),
        .gnt_idx  (gnt_idx),
        .next_ptr (next_ptr)
    );

    assign gnt_addr  = req_addr[int'(gnt_idx)*FL_ADDR_W +: FL_ADDR_W];
    assign dbg_state = state;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        ptr_n      = ptr;
        owner_n    = owner;
        req_ack_n  = '0;
        rd_valid_n = '0;
        rd_data_n  = rd_data;
        fl_a_n     = fl_a;
        fl_cs_n    = 1'b0;
        timeout_n  = timeout;
        case (state)
            BOOT: begin
                if (cnt == CNT_W'(BOOT_CYC - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (any_req) begin
                    req_ack_n = gnt_oh;
                    fl_a_n    = gnt_addr;
                    owner_n   = gnt_oh;
                    ptr_n     = next_ptr;
                    fl_cs_n   = 1'b1;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                // fl_cs is registered, so it is high exactly for the CS_HOLD cycles spent here.
                if (cnt == CNT_W'(CS_HOLD - 1)) begin
                    state_n = WAIT_BUSY;
                    cnt_n   = '0;
                end else begin
                    fl_cs_n = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (fl_busy) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(BUSY_TO - 1)) begin
                    timeout_n = 1'b1;
                    fl_cs_n   = 1'b1;
                    state_n   = ISSUE;
                    cnt_n     = '0;
                end
            end
            WAIT_DONE: begin
                cnt_n = '0;
                if (!fl_busy) begin
                    rd_data_n  = fl_o;
                    rd_valid_n = owner;
                    state_n    = DELIVER;
                end
            end
            DELIVER: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            cnt      <= '0;
            ptr      <= '0;
            owner    <= '0;
            req_ack  <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            fl_a     <= '0;
            fl_cs    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            req_ack  <= req_ack_n;
            rd_valid <= rd_valid_n;
            rd_data  <= rd_data_n;
            fl_a     <= fl_a_n;
            fl_cs    <= fl_cs_n;
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a behavioural flash reader and a result scoreboard.
module tb_flash_read_arbiter;
    import flash_pkg::*;

    localparam int NREQ     = 2;
    localparam int BOOT_CYC = 32;
    localparam int CS_HOLD  = 2;
    localparam int BUSY_TO  = 8;

    logic                      clk;
    logic                      rst;
    logic [NREQ-1:0]           req;
    logic [NREQ*FL_ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]           req_ack;
    logic [FL_DATA_W-1:0]      rd_data;
    logic [NREQ-1:0]           rd_valid;
    logic [FL_ADDR_W-1:0]      fl_a;
    logic                      fl_cs;
    logic [FL_DATA_W-1:0]      fl_o;
    logic                      fl_busy;
    logic                      timeout;
    arb_state_t                dbg_state;

    flash_read_arbiter #(
        .NREQ(NREQ), .BOOT_CYC(BOOT_CYC), .CS_HOLD(CS_HOLD), .BUSY_TO(BUSY_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_ack   (req_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .fl_a      (fl_a),
        .fl_cs     (fl_cs),
        .fl_o      (fl_o),
        .fl_busy   (fl_busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // behavioural flash reader: busy ~3 cycles after the strobe edge, 33 cycles busy
    logic                 model_dead;
    logic                 cs_q, m_active;
    logic [FL_ADDR_W-1:0] m_addr;
    int                   m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q <= 1'b0; m_active <= 1'b0; m_cnt <= 0; m_addr <= '0;
            fl_busy <= 1'b0; fl_o <= '0;
        end else begin
            cs_q <= fl_cs;
            if (fl_cs && !cs_q && !model_dead) begin
                m_active <= 1'b1; m_cnt <= 0; m_addr <= fl_a;
            end else if (m_active) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 2) fl_busy <= 1'b1;
                if (m_cnt == 35) begin
                    fl_busy  <= 1'b0;
                    fl_o     <= m_addr[15:0] ^ 16'hA5A5;
                    m_active <= 1'b0;
                end
            end
        end
    end

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // scoreboard: {owner index, data}
    logic [17:0] exp_q[$];
    logic [17:0] sb_e;

    always @(negedge clk) begin
        if (!rst && rd_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("rd_valid_owner", 32'(rd_valid), 32'd1 << sb_e[17:16]);
                check("rd_data", 32'(rd_data), 32'(sb_e[15:0]));
            end
        end
    end

    // strobe and address monitors
    logic                 cs_prev = 1'b0;
    int                   cs_run = 0, rise_cnt = 0, last_rise = 0, rise_gap = 0, ack_cnt = 0;
    logic [FL_ADDR_W-1:0] a_hold;
    logic                 a_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cs_prev = 1'b0;
            cs_run  = 0;
            a_valid = 1'b0;
        end else begin
            if (fl_cs && !cs_prev) begin
                rise_cnt++;
                rise_gap  = cyc - last_rise;
                last_rise = cyc;
                cs_run    = 1;
            end else if (fl_cs) begin
                cs_run++;
            end
            if (!fl_cs && cs_prev) check("cs_high_len", 32'(cs_run), 32'(CS_HOLD));
            if (fl_cs) check("cs_only_in_issue", 32'(dbg_state == ISSUE), 32'd1);
            cs_prev = fl_cs;
            if (req_ack != '0) begin
                ack_cnt++;
                a_hold  = fl_a;
                a_valid = 1'b1;
            end else if (a_valid && (dbg_state == ISSUE || dbg_state == WAIT_BUSY ||
                                     dbg_state == WAIT_DONE || dbg_state == DELIVER)) begin
                check("fl_a_stable", 32'(fl_a), 32'(a_hold));
            end
        end
    end

    // driver tasks
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int idx, input logic [FL_ADDR_W-1:0] addr);
        exp_q.push_back({2'(idx), addr[15:0] ^ 16'hA5A5});
    endtask

    task automatic set_addr(input int idx, input logic [FL_ADDR_W-1:0] addr);
        req_addr[idx*FL_ADDR_W +: FL_ADDR_W] = addr;
    endtask

    task automatic wait_ack(input string tag, input logic [NREQ-1:0] exp_oh, output int at);
        int n = 0;
        while (req_ack == '0 && n < 300) begin
            step();
            n++;
        end
        at = cyc;
        check(tag, 32'(req_ack), 32'(exp_oh));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input string tag, input arb_state_t st);
        int n = 0;
        while (dbg_state != st && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(dbg_state), 32'(st));
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_req_ack"}, 32'(req_ack), 32'd0);
        check({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
        check({pfx, "_fl_a"}, 32'(fl_a), 32'd0);
        check({pfx, "_fl_cs"}, 32'(fl_cs), 32'd0);
        check({pfx, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int at, r0, idx, n, acks_before;
        logic [FL_ADDR_W-1:0] addr;

        rst = 1'b1; req = '0; req_addr = '0; model_dead = 1'b0;
        step(3);
        check_outputs_zero("reset");
        rst = 1'b0;

        // first request during boot: held off until BOOT_CYC has elapsed
        step(4);
        set_addr(0, 23'h100000);
        push_exp(0, 23'h100000);
        req = 2'b01;
        wait_ack("boot_ack0", 2'b01, at);
        check("boot_ack_cycle", 32'(at), 32'(BOOT_CYC + 1));
        req = 2'b00;
        wait_drain("drain_boot");

        // requester 1 drops req right after ack; the read still completes
        set_addr(1, 23'h0ABCDE);
        push_exp(1, 23'h0ABCDE);
        req = 2'b10;
        wait_ack("ack_req1", 2'b10, at);
        req = 2'b00;
        wait_drain("drain_req1");

        // both held: pointer now prefers requester 0, grants alternate
        set_addr(0, 23'h000010);
        set_addr(1, 23'h000020);
        for (int k = 0; k < 4; k++) push_exp(k % 2, (k % 2) ? 23'h000020 : 23'h000010);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack("alt_grant", (k % 2) ? 2'b10 : 2'b01, at);
            if (k == 3) req = 2'b00;
            step();
        end
        wait_drain("drain_alt");

        // random single reads
        for (int k = 0; k < 3; k++) begin
            idx  = $urandom_range(0, NREQ - 1);
            addr = FL_ADDR_W'($urandom_range(0, 32'h7FFFFF));
            set_addr(idx, addr);
            push_exp(idx, addr);
            req = NREQ'(1) << idx;
            wait_ack("rand_ack", NREQ'(1) << idx, at);
            req = '0;
            wait_drain("drain_rand");
        end

        // reader never answers: re-strobe every CS_HOLD+BUSY_TO, sticky timeout, no new ack
        model_dead = 1'b1;
        set_addr(0, 23'h000123);
        req = 2'b01;
        wait_ack("to_ack", 2'b01, at);
        req = 2'b10;
        acks_before = ack_cnt;
        r0 = rise_cnt;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (rise_cnt == r0 + k && n < 50) begin
                step();
                n++;
            end
            check("restrobe_gap", 32'(rise_gap), 32'(CS_HOLD + BUSY_TO));
        end
        check("timeout_flag", 32'(timeout), 32'd1);
        check("no_second_ack", 32'(ack_cnt), 32'(acks_before));
        req = 2'b00;
        rst = 1'b1;
        exp_q.delete();
        step(2);
        check("timeout_cleared", 32'(timeout), 32'd0);
        model_dead = 1'b0;
        rst = 1'b0;

        // reset while waiting for the reader to finish
        set_addr(0, 23'h004444);
        push_exp(0, 23'h004444);
        req = 2'b01;
        wait_ack("abort_ack", 2'b01, at);
        req = 2'b00;
        wait_state("reach_wait_done", WAIT_DONE);
        step(5);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        check("abort_state", 32'(dbg_state), 32'(BOOT));
        exp_q.delete();
        step(3);
        rst = 1'b0;
        step(BOOT_CYC + 40);

        // normal read after the abort
        set_addr(1, 23'h007777);
        push_exp(1, 23'h007777);
        req = 2'b10;
        wait_ack("post_abort_ack", 2'b10, at);
        req = 2'b00;
        wait_drain("drain_post_abort");
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
